// File: rtl/serdes_rx_aligner.sv
// serdes_rx_aligner: receive-side word aligner and frame-lock engine.
// Finds the periodic sync word in a bit-rotated parallel stream, locks the
// bit offset and frame phase, then delivers aligned payload words with
// start-of-frame marking while watching for lost sync.
module serdes_rx_aligner #(
    parameter int                PWIDTH    = 20,
    parameter logic [PWIDTH-1:0] SYNC_WORD = 20'hF3A1C,
    parameter int                FRAME_LEN = 16,
    parameter int                LOCK_CNT  = 3,
    parameter int                MISS_MAX  = 2,
    parameter int                OW        = $clog2(PWIDTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [PWIDTH-1:0] i_rx_data,
    input  logic              i_realign,
    output logic [PWIDTH-1:0] o_data,
    output logic              o_valid,
    output logic              o_sof,
    output logic              o_locked,
    output logic [OW-1:0]     o_offset,
    output logic              o_sync_miss
);

    localparam int WW = $clog2(FRAME_LEN);
    localparam int HW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(MISS_MAX + 1);

    localparam logic [WW-1:0] WCNT_LAST = WW'(FRAME_LEN - 1);
    localparam logic [HW-1:0] HITS_LAST = HW'(LOCK_CNT - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(MISS_MAX - 1);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [PWIDTH-1:0]   r_prev;
    logic [2*PWIDTH-1:0] win;
    logic [PWIDTH-1:0]   match;
    logic                any_match;
    logic [OW-1:0]       first_k;
    logic [PWIDTH-1:0]   cand;
    logic                cand_ok;
    logic [1:0]          state;
    logic [WW-1:0]       wcnt;
    logic [WW-1:0]       wcnt_next;
    logic [HW-1:0]       hits;
    logic [MW-1:0]       miss;

    // The previous word plus the current one covers every possible bit rotation.
    assign win = {i_rx_data, r_prev};

    genvar gk;
    generate
        for (gk = 0; gk < PWIDTH; gk++) begin : g_match
            assign match[gk] = (win[gk +: PWIDTH] == SYNC_WORD);
        end
    endgenerate

    assign any_match = |match;

    // Lowest matching offset wins when the sync pattern appears at several offsets.
    always_comb begin
        first_k = '0;
        for (int k = PWIDTH - 1; k >= 0; k--) begin
            if (match[k]) begin
                first_k = k[OW-1:0];
            end
        end
    end

    // Word at the locked offset; offset 0 comes entirely from r_prev.
    assign cand    = PWIDTH'(win >> o_offset);
    assign cand_ok = (cand == SYNC_WORD);

    assign wcnt_next = (wcnt == WCNT_LAST) ? '0 : wcnt + 1'b1;

    // Keep one word of history so a word split across two raw words can be rebuilt.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= i_rx_data;
        end
    end

    // Hunt / verify / locked sequencing, frame phase counting and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_HUNT;
            wcnt        <= '0;
            hits        <= '0;
            miss        <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_sof       <= 1'b0;
            o_locked    <= 1'b0;
            o_offset    <= '0;
            o_sync_miss <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_sof       <= 1'b0;
            o_sync_miss <= 1'b0;
            if (i_realign) begin
                state    <= ST_HUNT;
                hits     <= '0;
                miss     <= '0;
                o_locked <= 1'b0;
            end else begin
                case (state)
                    ST_HUNT: begin
                        if (any_match) begin
                            o_offset <= first_k;
                            wcnt     <= WW'(1);
                            hits     <= HW'(1);
                            miss     <= '0;
                            if (LOCK_CNT == 1) begin
                                state <= ST_LOCKED;
                            end else begin
                                state <= ST_VERIFY;
                            end
                        end
                    end
                    ST_VERIFY: begin
                        wcnt <= wcnt_next;
                        if (wcnt == '0) begin
                            if (cand_ok) begin
                                hits <= hits + 1'b1;
                                if (hits == HITS_LAST) begin
                                    state <= ST_LOCKED;
                                    miss  <= '0;
                                end
                            end else begin
                                state <= ST_HUNT;
                                hits  <= '0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        wcnt <= wcnt_next;
                        if (wcnt != '0) begin
                            o_data   <= cand;
                            o_valid  <= 1'b1;
                            o_sof    <= (wcnt == WW'(1));
                            o_locked <= 1'b1;
                        end else if (cand_ok) begin
                            miss <= '0;
                        end else begin
                            o_sync_miss <= 1'b1;
                            if (miss == MISS_LAST) begin
                                state    <= ST_HUNT;
                                o_locked <= 1'b0;
                                miss     <= '0;
                                hits     <= '0;
                            end else begin
                                miss <= miss + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_HUNT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serdes_rx_aligner.sv
// Testbench for serdes_rx_aligner: feeds a serial bit stream of framed words
// at chosen rotations and checks the outputs every cycle against a
// frame-level model, plus hand-computed expectations at key points.
`timescale 1ns/1ps
module tb_serdes_rx_aligner;

    localparam int          PW   = 20;
    localparam logic [19:0] SYNC = 20'hF3A1C;
    localparam int          FL   = 16;
    localparam int          LC   = 3;
    localparam int          MM   = 2;
    localparam int          OWD  = 5;

    localparam int M_SEEK    = 0;
    localparam int M_CONFIRM = 1;
    localparam int M_TRACK   = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [PW-1:0]  rx_data = '0;
    logic           realign = 1'b0;
    logic [PW-1:0]  data;
    logic           valid;
    logic           sof;
    logic           locked;
    logic [OWD-1:0] offset;
    logic           sync_miss;

    int checks = 0;
    int errors = 0;

    bit          bitq[$];
    logic [19:0] got[$];
    logic [19:0] sof_vals[$];
    int          pulses = 0;

    int          m_mode;
    int          m_cyc;
    int          m_anchor;
    int          m_good;
    int          m_bad;
    int          m_off;
    logic [19:0] m_prev;
    logic [19:0] exp_data;
    logic        exp_valid;
    logic        exp_sof;
    logic        exp_locked;
    logic        exp_miss;

    serdes_rx_aligner #(
        .PWIDTH   (PW),
        .SYNC_WORD(SYNC),
        .FRAME_LEN(FL),
        .LOCK_CNT (LC),
        .MISS_MAX (MM),
        .OW       (OWD)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx_data  (rx_data),
        .i_realign  (realign),
        .o_data     (data),
        .o_valid    (valid),
        .o_sof      (sof),
        .o_locked   (locked),
        .o_offset   (offset),
        .o_sync_miss(sync_miss)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [19:0] word_at(input logic [39:0] w, input int k);
        logic [39:0] s;
        s = w >> k;
        return s[19:0];
    endfunction

    task automatic model_reset();
        m_mode     = M_SEEK;
        m_cyc      = 0;
        m_anchor   = 0;
        m_good     = 0;
        m_bad      = 0;
        m_off      = 0;
        m_prev     = '0;
        exp_data   = '0;
        exp_valid  = 1'b0;
        exp_sof    = 1'b0;
        exp_locked = 1'b0;
        exp_miss   = 1'b0;
    endtask

    // Frame-level model: frame phase is the cycle distance from the last detection.
    task automatic model_step(input logic [19:0] rx, input logic rl);
        logic [39:0] w;
        logic [19:0] c;
        int          slot;
        int          hit_k;
        w         = {rx, m_prev};
        c         = word_at(w, m_off);
        slot      = (m_cyc - m_anchor) % FL;
        exp_valid = 1'b0;
        exp_sof   = 1'b0;
        exp_miss  = 1'b0;
        if (rl) begin
            m_mode     = M_SEEK;
            m_good     = 0;
            m_bad      = 0;
            exp_locked = 1'b0;
        end else if (m_mode == M_SEEK) begin
            hit_k = -1;
            for (int k = 0; k < PW; k++) begin
                if (hit_k < 0 && word_at(w, k) == SYNC) hit_k = k;
            end
            if (hit_k >= 0) begin
                m_off    = hit_k;
                m_anchor = m_cyc;
                m_good   = 1;
                m_bad    = 0;
                m_mode   = (LC == 1) ? M_TRACK : M_CONFIRM;
            end
        end else if (m_mode == M_CONFIRM) begin
            if (slot == 0) begin
                if (c == SYNC) begin
                    m_good++;
                    if (m_good == LC) begin
                        m_mode = M_TRACK;
                        m_bad  = 0;
                    end
                end else begin
                    m_mode = M_SEEK;
                    m_good = 0;
                end
            end
        end else begin
            if (slot != 0) begin
                exp_data   = c;
                exp_valid  = 1'b1;
                exp_sof    = (slot == 1);
                exp_locked = 1'b1;
            end else if (c == SYNC) begin
                m_bad = 0;
            end else begin
                exp_miss = 1'b1;
                m_bad++;
                if (m_bad == MM) begin
                    m_mode     = M_SEEK;
                    exp_locked = 1'b0;
                    m_bad      = 0;
                    m_good     = 0;
                end
            end
        end
        m_prev = rx;
        m_cyc++;
    endtask

    task automatic push_word(input logic [19:0] w);
        for (int b = 0; b < PW; b++) bitq.push_back(w[b]);
    endtask

    task automatic push_junk(input int n);
        for (int b = 0; b < n; b++) bitq.push_back(1'b0);
    endtask

    task automatic push_frame(input logic [19:0] sw);
        push_word(sw);
        for (int i = 1; i < FL; i++) push_word(20'(i));
    endtask

    task automatic applyStimulus(input logic rl);
        logic [19:0] w;
        @(negedge clk);
        for (int b = 0; b < PW; b++) begin
            if (bitq.size() > 0) w[b] = bitq.pop_front();
            else w[b] = 1'b0;
        end
        rx_data = w;
        realign = rl;
        model_step(w, rl);
    endtask

    task automatic send_frame(input logic [19:0] sw, input int rs);
        push_frame(sw);
        for (int j = 0; j < FL; j++) begin
            applyStimulus(j == rs);
            if (j == rs) begin
                @(posedge clk);
                #2;
                checkOutput("realign_locked", {31'd0, locked}, 32'd0);
                checkOutput("realign_valid", {31'd0, valid}, 32'd0);
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        checkOutput("rst_data", {12'd0, data}, 32'd0);
        checkOutput("rst_valid", {31'd0, valid}, 32'd0);
        checkOutput("rst_sof", {31'd0, sof}, 32'd0);
        checkOutput("rst_locked", {31'd0, locked}, 32'd0);
        checkOutput("rst_offset", {27'd0, offset}, 32'd0);
        checkOutput("rst_sync_miss", {31'd0, sync_miss}, 32'd0);
        bitq.delete();
        got.delete();
        sof_vals.delete();
        pulses = 0;
        realign = 1'b0;
        rx_data = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Per-cycle comparison of every output against the model, plus payload capture.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            checkOutput("data", {12'd0, data}, {12'd0, exp_data});
            checkOutput("valid", {31'd0, valid}, {31'd0, exp_valid});
            checkOutput("sof", {31'd0, sof}, {31'd0, exp_sof});
            checkOutput("locked", {31'd0, locked}, {31'd0, exp_locked});
            checkOutput("offset", {27'd0, offset}, 32'(m_off));
            checkOutput("sync_miss", {31'd0, sync_miss}, {31'd0, exp_miss});
            if (valid === 1'b1) got.push_back(data);
            if (valid === 1'b1 && sof === 1'b1) sof_vals.push_back(data);
            if (sync_miss === 1'b1) pulses++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #2;
        do_reset();

        // Lock at rotation 7.
        push_junk(7);
        send_frame(SYNC, -1);
        send_frame(SYNC, -1);
        checkOutput("no_lock_before_third", {31'd0, locked}, 32'd0);
        send_frame(SYNC, -1);
        send_frame(SYNC, -1);
        checkOutput("lock_offset7", {27'd0, offset}, 32'd7);
        checkOutput("lock_locked", {31'd0, locked}, 32'd1);
        checkOutput("lock_count", 32'(got.size()), 32'd29);
        for (int i = 0; i < 15; i++) checkOutput("lock_payload", {12'd0, got[i]}, 32'(i + 1));
        checkOutput("lock_sof_count", 32'(sof_vals.size()), 32'd2);
        checkOutput("lock_sof_value", {12'd0, sof_vals[0]}, 32'd1);

        // Verify failure at rotation 3, then relock.
        do_reset();
        push_junk(3);
        send_frame(SYNC, -1);
        send_frame(20'h00000, -1);
        checkOutput("verify_fail_offset", {27'd0, offset}, 32'd3);
        send_frame(SYNC, -1);
        send_frame(SYNC, -1);
        checkOutput("verify_fail_unlocked", {31'd0, locked}, 32'd0);
        send_frame(SYNC, -1);
        checkOutput("verify_relock", {31'd0, locked}, 32'd1);
        checkOutput("verify_relock_offset", {27'd0, offset}, 32'd3);

        // Single corrupted sync while locked.
        got.delete();
        pulses = 0;
        send_frame(20'h00000, -1);
        send_frame(SYNC, -1);
        checkOutput("single_miss_pulses", 32'(pulses), 32'd1);
        checkOutput("single_miss_locked", {31'd0, locked}, 32'd1);
        checkOutput("single_miss_count", 32'(got.size()), 32'd30);
        for (int i = 0; i < 15; i++) checkOutput("single_miss_payload", {12'd0, got[i + 1]}, 32'(i + 1));

        // Two consecutive misses drop lock; relock at rotation 12.
        pulses = 0;
        send_frame(20'h00000, -1);
        send_frame(20'h00000, -1);
        checkOutput("loss_pulses", 32'(pulses), 32'd2);
        checkOutput("loss_locked", {31'd0, locked}, 32'd0);
        checkOutput("loss_valid", {31'd0, valid}, 32'd0);
        push_junk(9);
        send_frame(SYNC, -1);
        send_frame(SYNC, -1);
        send_frame(SYNC, -1);
        send_frame(SYNC, -1);
        checkOutput("relock_offset12", {27'd0, offset}, 32'd12);
        checkOutput("relock_locked", {31'd0, locked}, 32'd1);

        // Realign mid-frame at word 5.
        send_frame(SYNC, 6);
        send_frame(SYNC, -1);
        send_frame(SYNC, -1);
        checkOutput("realign_still_hunting", {31'd0, locked}, 32'd0);
        send_frame(SYNC, -1);
        checkOutput("realign_relock", {31'd0, locked}, 32'd1);
        checkOutput("realign_offset", {27'd0, offset}, 32'd12);

        // Reset in the middle of a payload run.
        push_frame(SYNC);
        repeat (8) applyStimulus(1'b0);
        @(posedge clk);
        #2;
        checkOutput("pre_reset_valid", {31'd0, valid}, 32'd1);
        checkOutput("pre_reset_data", {12'd0, data}, 32'd6);
        do_reset();
        push_junk(7);
        repeat (4) send_frame(SYNC, -1);
        checkOutput("post_reset_locked", {31'd0, locked}, 32'd1);
        checkOutput("post_reset_offset", {27'd0, offset}, 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
